// File: rtl/fixed_subframe_sequencer.sv
// Sequences one FIXED-predictor subframe through the shared restoration datapath:
// clear, stream blocksize samples under valid/ready, tag one-cycle-late results, pulse done.
module fixed_subframe_sequencer #(
  parameter int BLOCK_W   = 16,
  parameter int MAX_ORDER = 4
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iStart,
  input  logic [7:0]         iOrder,
  input  logic [BLOCK_W-1:0] iBlockSize,
  input  logic               iValid,
  input  logic [15:0]        iSample,
  output logic               oReady,
  output logic               oDecReset,
  output logic               oDecEnable,
  output logic [7:0]         oDecOrder,
  output logic [15:0]        oDecSample,
  input  logic [15:0]        iDecData,
  output logic               oValid,
  output logic [15:0]        oData,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [7:0]         MAX_ORD = 8'(MAX_ORDER);
  localparam logic [BLOCK_W-1:0] CNT_ONE = BLOCK_W'(1);

  state_t             state_q;
  logic [BLOCK_W-1:0] cnt_q;
  logic [BLOCK_W-1:0] cnt_d;
  logic [BLOCK_W-1:0] bsize_q;
  logic [7:0]         order_q;
  logic               valid_q;
  logic [15:0]        hold_q;
  logic               error_q;
  logic               accept;
  logic               last_accept;
  logic               cfg_bad;

  // Block size may be narrower or wider than the 8-bit order; compare both zero-extended.
  assign cfg_bad = (iOrder > MAX_ORD) || (iBlockSize == '0) ||
                   ({8'd0, iBlockSize} < {{BLOCK_W{1'b0}}, iOrder});

  assign oReady      = (state_q == S_RUN) && (cnt_q < bsize_q);
  assign accept      = iValid && oReady;
  assign cnt_d       = cnt_q + CNT_ONE;
  assign last_accept = accept && (cnt_d == bsize_q);

  assign oDecReset  = iReset || (state_q == S_CLEAR);
  assign oDecEnable = accept;
  assign oDecSample = iSample;
  assign oDecOrder  = order_q;
  assign oValid     = valid_q;
  assign oData      = valid_q ? iDecData : hold_q;
  assign oBusy      = (state_q != S_IDLE);
  assign oDone      = (state_q == S_DONE);
  assign oError     = error_q;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bsize_q <= '0;
      order_q <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      error_q <= 1'b0;
    end else begin
      valid_q <= accept;
      if (valid_q) begin
        hold_q <= iDecData;
      end
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            order_q <= iOrder;
            bsize_q <= iBlockSize;
            cnt_q   <= '0;
            error_q <= cfg_bad;
            state_q <= cfg_bad ? S_DONE : S_CLEAR;
          end
        end
        S_CLEAR: state_q <= S_RUN;
        S_RUN: begin
          if (accept) begin
            cnt_q <= cnt_d;
          end
          if (last_accept) begin
            state_q <= S_FLUSH;
          end
        end
        // FLUSH absorbs the datapath's one-cycle result latency.
        S_FLUSH: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_subframe_sequencer.sv
// Bench for fixed_subframe_sequencer: datapath stub, negedge monitor, and a
// reference that predicts restored samples from the binomial fixed-predictor rule.
module tb_fixed_subframe_sequencer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iStart = 1'b0;
  logic [7:0]  iOrder = '0;
  logic [15:0] iBlockSize = '0;
  logic        iValid = 1'b0;
  logic [15:0] iSample = '0;
  logic [15:0] iDecData = '0;
  logic        oReady, oDecReset, oDecEnable, oValid, oBusy, oDone, oError;
  logic [7:0]  oDecOrder;
  logic [15:0] oDecSample, oData;

  int vectors = 0;
  int miscompares = 0;

  fixed_subframe_sequencer #(.BLOCK_W(16), .MAX_ORDER(4)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iOrder(iOrder),
    .iBlockSize(iBlockSize), .iValid(iValid), .iSample(iSample),
    .oReady(oReady), .oDecReset(oDecReset), .oDecEnable(oDecEnable),
    .oDecOrder(oDecOrder), .oDecSample(oDecSample), .iDecData(iDecData),
    .oValid(oValid), .oData(oData), .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  always #5 iClock = ~iClock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Restoration datapath stub: fixed predictor with warm-up pass-through, one-cycle latency.
  logic [15:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;
  int dp_n = 0;

  function automatic logic [15:0] dp_fn(input logic [7:0] ord, input int n, input logic [15:0] r,
                                         input logic [15:0] a, b, c, d);
    int acc, sr, sa, sb, sc, sd;
    sr = $signed(r); sa = $signed(a); sb = $signed(b); sc = $signed(c); sd = $signed(d);
    if (n < int'(ord)) return r;
    case (ord)
      8'd1:    acc = sr + sa;
      8'd2:    acc = sr + 2*sa - sb;
      8'd3:    acc = sr + 3*sa - 3*sb + sc;
      8'd4:    acc = sr + 4*sa - 6*sb + 4*sc - sd;
      default: acc = sr;
    endcase
    return acc[15:0];
  endfunction

  always @(posedge iClock) begin
    if (oDecReset) begin
      h0 <= '0; h1 <= '0; h2 <= '0; h3 <= '0;
      dp_n <= 0;
      iDecData <= '0;
    end else if (oDecEnable) begin
      iDecData <= dp_fn(oDecOrder, dp_n, oDecSample, h0, h1, h2, h3);
      h0 <= dp_fn(oDecOrder, dp_n, oDecSample, h0, h1, h2, h3);
      h1 <= h0; h2 <= h1; h3 <= h2;
      dp_n <= dp_n + 1;
    end
  end

  // Monitor, sampled away from the active edge.
  int cyc = 0, nen = 0, nres = 0, ndone = 0, nbad = 0, nready = 0;
  int done_cyc = -1, last_val_cyc = -1, res_cyc = -1, first_en_cyc = -1;
  bit armed = 1'b0, prev_en = 1'b0;
  logic [15:0] outq[$];

  always @(negedge iClock) begin
    cyc = cyc + 1;
    if (oDecReset) begin nres = nres + 1; res_cyc = cyc; armed = 1'b1; end
    if (oDecEnable) begin
      nen = nen + 1;
      if (armed) begin first_en_cyc = cyc; armed = 1'b0; end
    end
    if (oValid) begin
      outq.push_back(oData);
      last_val_cyc = cyc;
      if (!prev_en) nbad = nbad + 1;
    end
    if (oDone) begin ndone = ndone + 1; done_cyc = cyc; end
    if (oReady) nready = nready + 1;
    prev_en = oDecEnable;
  end

  // Reference model: x[n] = s[n] for warm-up, else s[n] + sum_k (-1)^(k+1) C(ord,k) x[n-k].
  int stim_q[$];
  int exp_q[$];

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic build_expect(input int ord);
    int acc;
    shortint w;
    exp_q.delete();
    for (int n = 0; n < stim_q.size(); n++) begin
      if (n < ord) acc = stim_q[n];
      else begin
        acc = stim_q[n];
        for (int k = 1; k <= ord; k++)
          acc = acc + ((k % 2 == 1) ? 1 : -1) * binom(ord, k) * exp_q[n - k];
      end
      w = shortint'(acc);
      exp_q.push_back(int'(w));
    end
  endtask

  // Drives one subframe (mode 0 continuous, 1 alternating, 2 random gaps) and scores it.
  task automatic run_sub(input string name, input int ord, input int bs, input int mode,
                         input bit poke, input bit exp_err);
    int b_out, b_en, b_res, b_done, b_bad, b_rdy, start_cyc, idx, guard, t;
    logic [15:0] ev;
    bit acc;
    b_out = outq.size(); b_en = nen; b_res = nres; b_done = ndone; b_bad = nbad; b_rdy = nready;
    build_expect(ord);
    iStart = 1'b1; iOrder = 8'(ord); iBlockSize = 16'(bs);
    start_cyc = cyc;
    @(posedge iClock); #1;
    iStart = 1'b0;
    idx = 0; guard = 0;
    while (!exp_err && idx < stim_q.size() && guard < 400) begin
      case (mode)
        0: iValid = 1'b1;
        1: iValid = (guard % 2 == 0);
        default: iValid = ($urandom_range(99) >= 35);
      endcase
      t = stim_q[idx];
      iSample = t[15:0];
      if (poke && idx == 2) begin iStart = 1'b1; iOrder = 8'd5; iBlockSize = 16'd1; end
      @(negedge iClock);
      acc = iValid && oReady;
      @(posedge iClock); #1;
      iStart = 1'b0;
      if (acc) idx++;
      guard++;
    end
    iValid = 1'b0;
    if (guard >= 400) begin
      miscompares++;
      $display("FAIL %s accept_timeout: accepted %0d, required %0d", name, idx, stim_q.size());
    end
    guard = 0;
    while (oBusy && guard < 30) begin @(posedge iClock); #1; guard++; end
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++; $display("FAIL %s idle_timeout: oBusy=%b required 0", name, oBusy);
    end
    vectors++;
    if (ndone - b_done !== 1) begin
      miscompares++; $display("FAIL %s done_count: got %0d required 1", name, ndone - b_done);
    end
    vectors++;
    if (oError !== exp_err) begin
      miscompares++; $display("FAIL %s error_flag: got %b required %b", name, oError, exp_err);
    end
    if (exp_err) begin
      vectors++;
      if (done_cyc !== start_cyc + 2) begin
        miscompares++; $display("FAIL %s err_done_time: got %0d required %0d", name, done_cyc, start_cyc + 2);
      end
      vectors++;
      if ((nen - b_en) !== 0 || (nres - b_res) !== 0 || (nready - b_rdy) !== 0 || outq.size() !== b_out) begin
        miscompares++;
        $display("FAIL %s err_quiet: en=%0d res=%0d rdy=%0d out=%0d required all 0", name,
                 nen - b_en, nres - b_res, nready - b_rdy, outq.size() - b_out);
      end
    end else begin
      vectors++;
      if (outq.size() - b_out !== bs) begin
        miscompares++; $display("FAIL %s out_count: got %0d required %0d", name, outq.size() - b_out, bs);
      end
      for (int i = 0; i < bs && b_out + i < outq.size(); i++) begin
        t = exp_q[i]; ev = t[15:0];
        vectors++;
        if (outq[b_out + i] !== ev) begin
          miscompares++; $display("FAIL %s data[%0d]: got %0d required %0d", name, i,
                                  $signed(outq[b_out + i]), $signed(ev));
        end
      end
      vectors++;
      if ((nen - b_en) !== bs || (nres - b_res) !== 1 || res_cyc !== start_cyc + 2 ||
          first_en_cyc <= res_cyc) begin
        miscompares++;
        $display("FAIL %s enable_clear: en=%0d res=%0d res_cyc=%0d first_en=%0d required en=%0d res=1 res_cyc=%0d",
                 name, nen - b_en, nres - b_res, res_cyc, first_en_cyc, bs, start_cyc + 2);
      end
      vectors++;
      if (done_cyc !== last_val_cyc + 1 || nbad !== b_bad) begin
        miscompares++;
        $display("FAIL %s done_after_last: done=%0d last_valid=%0d stray_valid=%0d required done=%0d stray=0",
                 name, done_cyc, last_val_cyc, nbad - b_bad, last_val_cyc + 1);
      end
      vectors++;
      if (oDecOrder !== 8'(ord)) begin
        miscompares++; $display("FAIL %s dec_order: got %0d required %0d", name, oDecOrder, ord);
      end
      if (mode == 0) begin
        vectors++;
        if (done_cyc !== start_cyc + bs + 4) begin
          miscompares++; $display("FAIL %s done_latency: got %0d required %0d", name, done_cyc, start_cyc + bs + 4);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge iClock);
    @(negedge iClock);
    vectors++;
    if ({oReady, oDecEnable, oValid, oDone, oError, oBusy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: rdy/en/vld/done/err/busy=%b required 000000",
               {oReady, oDecEnable, oValid, oDone, oError, oBusy});
    end
    vectors++;
    if (oDecOrder !== 8'd0 || oData !== 16'd0) begin
      miscompares++; $display("FAIL reset_regs: order=%0d data=%0d required 0 0", oDecOrder, oData);
    end
    vectors++;
    if (oDecReset !== 1'b1) begin
      miscompares++; $display("FAIL reset_decreset: got %b required 1", oDecReset);
    end
    @(posedge iClock); #1;
    iReset = 1'b0;
    iStart = 1'b1;                 // start coincident with reset must be dropped
    @(posedge iClock); #1;
    iStart = 1'b0;
  endtask

  task automatic test_start_under_reset();
    iReset = 1'b1; iStart = 1'b1; iOrder = 8'd1; iBlockSize = 16'd2;
    @(posedge iClock); #1;
    iReset = 1'b0; iStart = 1'b0;
    @(negedge iClock);
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++; $display("FAIL start_vs_reset: oBusy=%b required 0", oBusy);
    end
    @(posedge iClock); #1;
  endtask

  task automatic test_order2_continuous();
    stim_q = '{10, 20, 1, 1, 1, 1};
    run_sub("order2_cont", 2, 6, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gapped_order0();
    stim_q = '{5, -3, 7};
    run_sub("order0_gaps", 0, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_config_error();
    stim_q.delete();
    run_sub("err_order5", 5, 8, 0, 1'b0, 1'b1);
    stim_q = '{3, 4};
    run_sub("after_err", 1, 2, 0, 1'b0, 1'b0);
    stim_q.delete();
    run_sub("err_bs_lt_order", 4, 3, 0, 1'b0, 1'b1);
    stim_q = '{9};
    run_sub("single", 1, 1, 0, 1'b0, 1'b0);
    stim_q.delete();
    run_sub("err_bs0", 0, 0, 0, 1'b0, 1'b1);
    stim_q = '{1, 2, 3, 4};
    run_sub("bs_eq_order", 4, 4, 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int got, guard, b_done;
    bit acc;
    iStart = 1'b1; iOrder = 8'd1; iBlockSize = 16'd6;
    @(posedge iClock); #1;
    iStart = 1'b0;
    got = 0; guard = 0;
    while (got < 3 && guard < 20) begin
      iValid = 1'b1; iSample = 16'(got + 2);
      @(negedge iClock);
      acc = oReady;
      @(posedge iClock); #1;
      if (acc) got++;
      guard++;
    end
    iValid = 1'b0; iReset = 1'b1;
    b_done = ndone;
    @(negedge iClock);
    vectors++;
    if (oDecReset !== 1'b1) begin
      miscompares++; $display("FAIL midreset_decreset: got %b required 1", oDecReset);
    end
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock);
    vectors++;
    if (oBusy !== 1'b0 || oValid !== 1'b0 || oReady !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: busy=%b valid=%b ready=%b accepted=%0d required 0 0 0 after 3",
               oBusy, oValid, oReady, got);
    end
    repeat (5) @(posedge iClock);
    #1;
    vectors++;
    if (ndone !== b_done) begin
      miscompares++; $display("FAIL midreset_nodone: got %0d done pulses required 0", ndone - b_done);
    end
    stim_q = '{4, 1, 1};
    run_sub("after_midreset", 1, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_during_run();
    stim_q = '{7, -2, 30, 5, -9, 12};
    run_sub("start_in_run", 3, 6, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int ord, bs, v;
    for (int it = 0; it < 8; it++) begin
      ord = $urandom_range(4);
      bs = $urandom_range(12, (ord == 0) ? 1 : ord);
      stim_q.delete();
      for (int i = 0; i < bs; i++) begin
        v = $urandom_range(200);
        stim_q.push_back(v - 100);
      end
      run_sub($sformatf("rand%0d_o%0d_b%0d", it, ord, bs), ord, bs, 2, it[0], 1'b0);
    end
    stim_q.delete();
    run_sub("rand_err", $urandom_range(255, 5), $urandom_range(20, 1), 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_start_under_reset();
    test_order2_continuous();
    test_gapped_order0();
    test_config_error();
    test_reset_mid();
    test_start_during_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fixed_subframe_sequencer.md
Name: fixed_subframe_sequencer

Overview:
Controls one FIXED-predictor subframe decode on the shared fixed-order restoration datapath (16-bit samples, orders 0-4, one sample per enable, one-cycle result latency).
- Takes a start command with order and block size.
- Clears the datapath and streams warm-up and residual samples into it under a valid/ready handshake.
- Counts samples and tags each restored output as valid.
- Signals completion or configuration error.
- Sits between the residual/warm-up sample source and the channel output stage.

Parameters:
BLOCK_W, 16, width of block-size field and sample counter
MAX_ORDER, 4, highest legal fixed predictor order

Ports:
iClock  in  1  clock
iReset  in  1  synchronous, active-high reset
iStart  in  1  start pulse; honoured only in IDLE
iOrder  in  8  predictor order, latched on accepted iStart
iBlockSize  in  BLOCK_W  samples in subframe, latched on accepted iStart
iValid  in  1  upstream sample valid
iSample  in  16  signed warm-up sample or residual, in stream order
oReady  out  1  sequencer accepts iSample this cycle
oDecReset  out  1  clear to restoration datapath
oDecEnable  out  1  advance restoration datapath
oDecOrder  out  8  latched order to datapath
oDecSample  out  16  sample to datapath (pass-through of iSample)
iDecData  in  16  signed restored sample from datapath
oValid  out  1  oData holds a new restored sample
oData  out  16  restored sample
oBusy  out  1  state != IDLE
oDone  out  1  one-cycle pulse at end of subframe
oError  out  1  sticky config error; cleared by next accepted iStart or reset

Behaviour:
- Reset: synchronous, active-high, on iReset; clock iClock. Reset values:
  - state=IDLE; counter=0.
  - oReady, oDecEnable, oValid, oDone, oError, oBusy = 0.
  - oDecOrder=0; oData=0.
  - oDecReset=1 during reset (oDecReset = iReset OR state==CLEAR).
- States: IDLE, CLEAR, RUN, FLUSH, DONE.
- IDLE:
  - On iStart, latch order and block size and clear oError.
  - If order > MAX_ORDER, or blocksize==0, or blocksize < order: set oError and go to DONE.
  - Otherwise go to CLEAR.
  - iStart is ignored in every other state.
- CLEAR (1 cycle): oDecReset=1, then go to RUN.
- RUN:
  - oReady=1 while counter < blocksize.
  - Accept = iValid AND oReady. On accept: oDecEnable=1 (combinational), oDecSample=iSample, counter+1.
  - iValid low gives no enable; the datapath holds state, so gaps of any length are legal.
  - When the accepted sample is number blocksize (counter == blocksize-1 at accept), go to FLUSH. oReady is 0 from the next cycle on.
- FLUSH (1 cycle): covers the datapath latency, then go to DONE.
- DONE (1 cycle): oDone=1, then go to IDLE.
- Output tagging:
  - oValid is registered as the accept of the previous cycle.
  - oData equals iDecData while oValid=1, and holds its last value otherwise.
  - Exactly blocksize oValid pulses per error-free subframe. The last pulse coincides with the FLUSH cycle.
- Warm-up samples are not treated specially here. The datapath passes the first `order` samples through; the sequencer simply counts all of them.
- Width rules:
  - Counter is BLOCK_W bits, compared unsigned.
  - Order comparison is 8-bit unsigned.
  - No arithmetic is performed on sample data.
- Error path: no oDecReset and no oDecEnable; oDone pulses 1 cycle after iStart's IDLE cycle; oError stays high.
- Reset mid-operation: returns to IDLE next edge. In-flight oValid is dropped, no oDone is issued, and the datapath is cleared via oDecReset.
- iStart coincident with iReset: reset wins.

Test Plan:
- Order 2, block 6, stream 10,20,1,1,1,1 with iValid continuous -> oValid on 6 consecutive cycles, oData 10,20,31,43,56,70; oDone one cycle after the final value; one oDecReset pulse before the first enable.
- Order 0, block 3, stream 5,-3,7 with iValid low every other cycle -> exactly 3 enables, oData 5,-3,7; no oValid in gap cycles.
- Order 5, block 8 -> oError=1, oDone pulse, zero oDecEnable/oDecReset, oReady never high. Then order 1, block 2 start -> oError clears.
- Order 4, block 3 -> error. Order 1, block 1, stream 9 -> single output 9, then oDone.
- iReset asserted after 3 of 6 accepted samples -> IDLE next cycle, oBusy=0, no oDone. Restart order 1, block 3, stream 4,1,1 -> 4,5,6.
- iStart pulsed again during RUN -> ignored; outputs unchanged from the uninterrupted run.
